// File: rtl/lsu_ahb_pkg.sv
// Shared types, rwtyp encodings and data-path helpers for the LSU-to-AHB bridge.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package lsu_ahb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } lsu_ahb_state_e;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    function automatic logic req_illegal(input logic we, input logic [2:0] rwtyp,
                                         input logic [1:0] a);
        case (rwtyp)
            RW_B:    return 1'b0;
            RW_H:    return a[0];
            RW_W:    return a != 2'b00;
            RW_BU:   return we;
            RW_HU:   return we | a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] rwtyp, input logic [31:0] w);
        case (rwtyp)
            RW_B:    return {4{w[7:0]}};
            RW_H:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] rwtyp, input logic [1:0] a,
                                                 input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (rwtyp)
            RW_B:    return {{24{b[7]}}, b};
            RW_BU:   return {24'b0, b};
            RW_H:    return {{16{h[15]}}, h};
            RW_HU:   return {16'b0, h};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ahb_wdt.sv
// Data-phase watchdog for lsu_ahb_master; only built when LSU_AHB_TIMEOUT_EN is defined.
module lsu_ahb_wdt #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= count + CW'(1);
    end

    // Fires on the wait cycle that brings the count up to LIMIT.
    assign expired = inc && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/lsu_ahb_master.sv
// Single-outstanding AHB-lite master for the LSU; optional data-phase watchdog
// under LSU_AHB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   ADDR  | address phase, hsel high for one cycle
//   DATA  | data phase, waiting for hready (or watchdog)
//   RESP  | one-cycle response pulse to the LSU
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module lsu_ahb_master
    import lsu_ahb_pkg::*;
#(
    parameter int AW             = `AHB_ADDR_WIDTH,
    parameter int DW             = `AHB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_we,
    input  logic [DW-1:0] req_wdata,
    input  logic [2:0]    req_rwtyp,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          hsel,
    output logic [AW-1:0] haddr,
    output logic          hwrite,
    output logic [DW-1:0] hwdata,
    output logic [2:0]    hrwtyp,
    input  logic          hready,
    input  logic          hresp,
    input  logic [DW-1:0] hrdata
);
    lsu_ahb_state_e state;
    logic           timeout;

`ifdef LSU_AHB_TIMEOUT_EN
    lsu_ahb_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (state == ST_ADDR),
        .inc     ((state == ST_DATA) && !hready),
        .expired (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    assign req_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            hsel       <= 1'b0;
            haddr      <= '0;
            hwrite     <= 1'b0;
            hwdata     <= '0;
            hrwtyp     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_illegal(req_we, req_rwtyp, req_addr[1:0])) begin
                            // Rejected without any bus activity.
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state  <= ST_ADDR;
                            hsel   <= 1'b1;
                            haddr  <= req_addr;
                            hwrite <= req_we;
                            hrwtyp <= req_rwtyp;
                            hwdata <= req_we ? store_lanes(req_rwtyp, req_wdata) : '0;
                        end
                    end
                end
                ST_ADDR: begin
                    hsel  <= 1'b0;
                    state <= ST_DATA;
                end
                ST_DATA: begin
                    if (hready) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        if (hresp)
                            resp_err <= 1'b1;
                        else if (!hwrite)
                            resp_rdata <= load_extract(hrwtyp, haddr[1:0], hrdata);
                    end else if (timeout) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ahb_master.sv
// Directed self-checking bench for lsu_ahb_master; timeout section follows LSU_AHB_TIMEOUT_EN.
module tb_lsu_ahb_master;
    import lsu_ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_rwtyp = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [2:0]  hrwtyp;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    logic hsel_q = 1'b0;

    lsu_ahb_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .req_rwtyp  (req_rwtyp),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .hsel       (hsel),
        .haddr      (haddr),
        .hwrite     (hwrite),
        .hwdata     (hwdata),
        .hrwtyp     (hrwtyp),
        .hready     (hready),
        .hresp      (hresp),
        .hrdata     (hrdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // hsel must never be high in two consecutive cycles.
    always @(negedge clk) begin
        if (rstn) check("hsel_single", {31'b0, hsel_q & hsel}, 32'h0);
        hsel_q = hsel;
    end

    // Presents a request at a negedge; returns at the negedge of cycle E+1.
    task automatic issue(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_rwtyp = typ;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // lat = k when resp_valid is seen k negedges after E (call at negedge E+1); -1 if none.
    task automatic wait_resp(input int max, output int l);
        l = -1;
        for (int i = 1; i <= max; i++) begin
            if (resp_valid) begin
                l = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_check(input string tag, input logic [2:0] typ, input logic [31:0] addr,
                              input logic [31:0] exp);
        int l;
        issue(1'b0, typ, addr, 32'h0);
        wait_resp(10, l);
        check({tag, "_lat"}, 32'(l), 32'd3);
        check({tag, "_rdata"}, resp_rdata, exp);
        check({tag, "_err"}, {31'b0, resp_err}, 32'h0);
    endtask

    task automatic illegal_check(input string tag, input logic we, input logic [2:0] typ,
                                 input logic [31:0] addr);
        int l;
        issue(we, typ, addr, 32'hFFFF_FFFF);
        check({tag, "_hsel"}, {31'b0, hsel}, 32'h0);
        wait_resp(5, l);
        check({tag, "_lat"}, 32'(l), 32'd1);
        check({tag, "_err"}, {31'b0, resp_err}, 32'h1);
        check({tag, "_rdata"}, resp_rdata, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hsel", {31'b0, hsel}, 32'h0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_haddr", haddr, 32'h0);
        rstn = 1'b1;

        // Zero-wait SW
        issue(1'b1, RW_W, 32'h100, 32'hDEAD_BEEF);
        check("sw_hsel_e1", {31'b0, hsel}, 32'h1);
        check("sw_hwrite_e1", {31'b0, hwrite}, 32'h1);
        check("sw_haddr_e1", haddr, 32'h100);
        check("sw_ready_e1", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        check("sw_hsel_e2", {31'b0, hsel}, 32'h0);
        check("sw_hwdata_e2", hwdata, 32'hDEAD_BEEF);
        check("sw_resp_e2", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        check("sw_resp_e3", {31'b0, resp_valid}, 32'h1);
        check("sw_err_e3", {31'b0, resp_err}, 32'h0);
        check("sw_rdata_e3", resp_rdata, 32'h0);
        @(negedge clk);
        check("sw_resp_e4", {31'b0, resp_valid}, 32'h0);
        check("sw_ready_e4", {31'b0, req_ready}, 32'h1);

        // SB lane replication
        issue(1'b1, RW_B, 32'h1, 32'h0000_00AB);
        @(negedge clk);
        check("sb_hwdata", hwdata, 32'hABAB_ABAB);
        @(negedge clk);
        check("sb_resp", {31'b0, resp_valid}, 32'h1);

        // Loads with extension
        hrdata = 32'h80FF_0000;
        load_check("lb_103", RW_B, 32'h103, 32'hFFFF_FF80);
        load_check("lbu_103", RW_BU, 32'h103, 32'h0000_0080);
        load_check("lhu_102", RW_HU, 32'h102, 32'h0000_80FF);
        load_check("lh_102", RW_H, 32'h102, 32'hFFFF_80FF);
        load_check("lb_102", RW_B, 32'h102, 32'hFFFF_FFFF);
        load_check("lb_101", RW_B, 32'h101, 32'h0000_0000);
        load_check("lh_100", RW_H, 32'h100, 32'h0000_0000);
        load_check("lw_100", RW_W, 32'h100, 32'h80FF_0000);
        hrdata = 32'h0000_7F01;
        load_check("lh_000", RW_H, 32'h0, 32'h0000_7F01);
        load_check("lb_000", RW_B, 32'h0, 32'h0000_0001);

        // SH with three wait states
        hready = 1'b0;
        issue(1'b1, RW_H, 32'h2, 32'h1234_ABCD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sh_wait_hwdata", hwdata, 32'hABCD_ABCD);
            check("sh_wait_resp", {31'b0, resp_valid}, 32'h0);
        end
        @(negedge clk);
        hready = 1'b1;
        check("sh_hwdata_last", hwdata, 32'hABCD_ABCD);
        check("sh_resp_pre", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        check("sh_resp", {31'b0, resp_valid}, 32'h1);
        check("sh_err", {31'b0, resp_err}, 32'h0);

        // Illegal requests
        illegal_check("ill_lw_101", 1'b0, RW_W, 32'h101);
        illegal_check("ill_t011", 1'b0, 3'b011, 32'h0);
        illegal_check("ill_lh_001", 1'b0, RW_H, 32'h1);
        illegal_check("ill_lhu_003", 1'b0, RW_HU, 32'h3);
        illegal_check("ill_st_bu", 1'b1, RW_BU, 32'h0);
        illegal_check("ill_t110", 1'b0, 3'b110, 32'h0);
        illegal_check("ill_t111", 1'b1, 3'b111, 32'h4);

        // Slave error
        hresp  = 1'b1;
        hrdata = 32'hCAFE_F00D;
        issue(1'b0, RW_W, 32'h10, 32'h0);
        wait_resp(10, lat);
        check("berr_lat", 32'(lat), 32'd3);
        check("berr_err", {31'b0, resp_err}, 32'h1);
        check("berr_rdata", resp_rdata, 32'h0);
        hresp = 1'b0;

        // Request held across RESP is taken at the first IDLE edge
        hrdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_rwtyp = RW_W; req_addr = 32'h8;
        @(posedge clk);
        @(negedge clk);
        check("b2b_ready_e1", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("b2b_resp1", {31'b0, resp_valid}, 32'h1);
        check("b2b_rdata1", resp_rdata, 32'h1122_3344);
        @(negedge clk);
        check("b2b_ready_e4", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_hsel_e5", {31'b0, hsel}, 32'h1);
        wait_resp(10, lat);
        check("b2b_lat2", 32'(lat), 32'd3);

        // Reset during a data-phase wait
        hready = 1'b0;
        issue(1'b0, RW_W, 32'h20, 32'h0);
        repeat (5) begin
            @(negedge clk);
            check("rw_no_resp", {31'b0, resp_valid}, 32'h0);
        end
        #2 rstn = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_rwtyp = RW_W; req_addr = 32'h0;
        #1;
        check("mrst_hsel", {31'b0, hsel}, 32'h0);
        check("mrst_haddr", haddr, 32'h0);
        check("mrst_hwrite", {31'b0, hwrite}, 32'h0);
        check("mrst_hwdata", hwdata, 32'h0);
        check("mrst_hrwtyp", {29'b0, hrwtyp}, 32'h0);
        check("mrst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("mrst_rdata", resp_rdata, 32'h0);
        check("mrst_err", {31'b0, resp_err}, 32'h0);
        check("mrst_ready", {31'b0, req_ready}, 32'h1);
        hready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("inrst_hsel", {31'b0, hsel}, 32'h0);
            check("inrst_resp", {31'b0, resp_valid}, 32'h0);
        end
        req_valid = 1'b0;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_resp", {31'b0, resp_valid}, 32'h0);
            check("postrst_hsel", {31'b0, hsel}, 32'h0);
        end
        hrdata = 32'h1234_5678;
        load_check("postrst_lw", RW_W, 32'h0, 32'h1234_5678);

        // Stuck slave
        hready = 1'b0;
        issue(1'b0, RW_W, 32'h40, 32'h0);
`ifdef LSU_AHB_TIMEOUT_EN
        wait_resp(30, lat);
        check("wdt_lat", 32'(lat), 32'd10);
        check("wdt_err", {31'b0, resp_err}, 32'h1);
        check("wdt_rdata", resp_rdata, 32'h0);
        hready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("wdt_no_late", {31'b0, resp_valid}, 32'h0);
        end
`else
        wait_resp(1000, lat);
        check("nowdt_no_resp", 32'(lat), 32'hFFFF_FFFF);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        hready = 1'b1;
`endif
        load_check("final_lw", RW_W, 32'h4, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ahb_master.md
# lsu_ahb_master

AHB-lite master bridge between the core load/store unit and the AHB data fabric; it is the stage directly upstream of the RAM slave (hsel/haddr/hwrite/hwdata out, hready/hresp/hrdata in). It accepts one load or store request at a time and runs a non-pipelined address phase followed by a data phase. It performs sub-word store-lane replication, load byte/half extraction with sign/zero extension, and misalignment checking. It returns a single-cycle response to the LSU.

## Interface
- `AW`, default `AHB_ADDR_WIDTH`: address width.
- `DW`, default `AHB_DATA_WIDTH` (32): data width; only 32 is supported.
- `TIMEOUT_CYCLES`, default 256: watchdog limit in cycles; used only when the watchdog is compiled in.

- `clk` in 1: the block's single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: LSU request present.
- `req_ready` out 1: high exactly when the FSM is in IDLE.
- `req_addr` in AW: byte address.
- `req_we` in 1: 1 selects store, 0 selects load.
- `req_wdata` in DW: store data, right-aligned.
- `req_rwtyp` in 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `resp_valid` out 1: one-cycle response pulse; the LSU cannot apply backpressure.
- `resp_rdata` out DW: extended load data; 0 for stores and for errors.
- `resp_err` out 1: misaligned access, illegal type, bus error, or timeout.
- `hsel` out 1: slave select, high during the address phase only.
- `haddr` out AW: unmodified req_addr.
- `hwrite` out 1: transfer direction.
- `hwdata` out DW: lane-replicated store data.
- `hrwtyp` out 3: access type forwarded to the slave.
- `hready` in 1: data phase complete.
- `hresp` in 1: 1 signals a slave error.
- `hrdata` in DW: read data.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On `req_valid`, latch the request.
  - If the request is legal, go to ADDR.
  - If it is illegal, go to RESP with err=1 and do not touch the bus.
- Illegal requests:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - rwtyp ∈ {011, 110, 111}.
  - A store with rwtyp ∈ {100, 101}.
- ADDR: `hsel`=1, `haddr`/`hwrite`/`hrwtyp` valid; always lasts one cycle, then go to DATA.
- DATA:
  - `hsel`=0; `hwdata` valid (stores only) and held until completion.
  - Each cycle with `hready`=1 completes the transfer: capture the result, go to RESP.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- Store lanes:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extraction:
  - Bytes are selected by addr[1:0]; halfwords by addr[1].
  - B/H are sign-extended; BU/HU are zero-extended.
- If `hresp`=1 when `hready`=1: err=1 and rdata=0.
- Reset value of every registered output is 0: `hsel`, `haddr`, `hwrite`, `hwdata`, `hrwtyp`, `resp_valid`, `resp_rdata`, `resp_err`.
- The FSM resets to IDLE. `req_ready` follows the state and therefore reads 1 while in reset, but no request is latched while `rstn` is low.
- A reset mid-transaction abandons it and produces no response.

## Timing
- A request is accepted at the edge where `req_valid`&`req_ready` is high; call this edge E.
- Legal transfer:
  - `hsel` is high in the cycle after E.
  - The data phase starts at E+2.
  - `resp_valid` rises one cycle after the first sampled `hready`=1.
  - With a zero-wait slave, `resp_valid` is high in cycle E+3.
- Illegal request: `resp_valid` is high in cycle E+1.
- Minimum request spacing is 4 cycles. A request held across RESP is accepted at the first IDLE edge.
- `hwdata` is stable for the whole data phase, including wait states. `hsel` is never high in two consecutive cycles.

## Configuration
- `LSU_AHB_TIMEOUT_EN` defined:
  - A counter clears on entry to DATA and increments on each DATA cycle with `hready`=0.
  - When the count reaches `TIMEOUT_CYCLES`, go to RESP with err=1 and rdata=0.
  - Any late `hready` from the abandoned transfer is ignored.
- Macro undefined: no counter is built, DATA waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `lsu_ahb_pkg` holds:
  - The state enum `lsu_ahb_state_e`.
  - The rwtyp encoding constants `RW_B`, `RW_H`, `RW_W`, `RW_BU`, `RW_HU`.
  - The function that builds store lanes.
  - The function that extracts load data.
- Width defaults come from the existing `AHB_*` defines.
- One sub-module, `lsu_ahb_wdt`, contains the timeout counter. It is instantiated only under `LSU_AHB_TIMEOUT_EN`.

## Test plan
- Zero-wait SW to addr 0x100 with wdata 0xDEADBEEF: in cycle E+1, `hsel`=1, `hwrite`=1, `haddr`=0x100; in E+2, `hwdata`=0xDEADBEEF; in E+3, `resp_valid`=1 and `resp_err`=0.
- LB at 0x103 with hrdata 0x80FF0000 gives resp_rdata 0xFFFFFF80. LBU at the same address gives 0x00000080. LHU at 0x102 gives 0x000080FF.
- SH with wdata 0x1234ABCD at 0x2 gives `hwdata` 0xABCDABCD, held through 3 wait states (`hready`=0). `resp_valid` appears one cycle after `hready` rises.
- LW at 0x101, and rwtyp 011 at 0x0: `hsel` never asserts; `resp_valid`=1 and `resp_err`=1 in E+1; rdata=0.
- Slave returns `hresp`=1 with `hready`=1 on an LW: `resp_err`=1, `resp_rdata`=0. Then drop `rstn` during a 10-cycle wait on a second LW: all outputs are 0, no `resp_valid` pulse, and the next request completes normally.
- With `LSU_AHB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, hold `hready`=0: `resp_err` pulses after 8 wait cycles. Without the macro, there is no response after 1000 cycles.
